tl_burst_arbiter: RTL and testbench

TL_BURST_ARBITER -- requirements
Module: tl_burst_arbiter

---
 rtl/tl_pkg.sv | 27 ++
 rtl/tl_burst_arbiter_if.sv | 23 ++
 rtl/tl_rr_picker.sv | 22 ++
 rtl/tl_burst_arbiter.sv | 78 +++++++
 tb/tb_tl_burst_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink A-channel types, opcodes and arbiter enums shared by the burst arbiter slice.
package tl_pkg;
  typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;
  typedef enum logic [1:0] {IDLE, HOLD, BURST} arb_state_e;
  typedef enum logic [2:0] {
    PUT_FULL_DATA    = 3'd0,
    PUT_PARTIAL_DATA = 3'd1,
    ARITHMETIC_DATA  = 3'd2,
    LOGICAL_DATA     = 3'd3,
    GET              = 3'd4,
    INTENT           = 3'd5,
    ACQUIRE_BLOCK    = 3'd6,
    ACQUIRE_PERM     = 3'd7
  } tl_a_op_e;
  typedef struct packed {
    tl_a_op_e    opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } tl_a_chan_t;
  function automatic logic is_data_op(tl_a_op_e op);
    return op inside {PUT_FULL_DATA, PUT_PARTIAL_DATA, ARITHMETIC_DATA, LOGICAL_DATA};
  endfunction
endpackage

// File: rtl/tl_burst_arbiter_if.sv
// tl_burst_arbiter_if: upstream A-channel fan-in, downstream A-channel and lock status of the burst arbiter.
interface tl_burst_arbiter_if import tl_pkg::*; #(
  parameter int N_MASTER = 4,
  parameter type DATA_T = tl_a_chan_t
);
  localparam int IW = N_MASTER > 1 ? $clog2(N_MASTER) : 1;
  DATA_T                inp_bits_i [N_MASTER];
  logic [N_MASTER-1:0]  inp_valid_i;
  logic [N_MASTER-1:0]  inp_ready_o;
  DATA_T                oup_bits_o;
  logic                 oup_valid_o;
  logic                 oup_ready_i;
  logic                 lock_valid_o;
  logic [IW-1:0]        lock_idx_o;
  modport slave (
    input  inp_bits_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_bits_o, oup_valid_o, lock_valid_o, lock_idx_o
  );
  modport master (
    output inp_bits_i, inp_valid_i, oup_ready_i,
    input  inp_ready_o, oup_bits_o, oup_valid_o, lock_valid_o, lock_idx_o
  );
endinterface

// File: rtl/tl_rr_picker.sv
// tl_rr_picker: picks the first requester at or after base_i, wrapping around; purely combinational.
module tl_rr_picker #(
  parameter int N = 4,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] base_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  int j;
  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(base_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) idx_o = IW'(j);
    end
  end
endmodule

// File: rtl/tl_burst_arbiter.sv
// tl_burst_arbiter: N-way TileLink A-channel arbiter; zero-latency pass-through that locks the
// grant while a stalled request is held or a multi-beat data burst is in flight.
module tl_burst_arbiter import tl_pkg::*; #(
  parameter int        N_MASTER   = 4,
  parameter type       DATA_T     = tl_a_chan_t,
  parameter int        BEAT_BYTES = 8,
  parameter int        MAX_SIZE   = 8,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input logic               clk_i,
  input logic               rst_i,
  tl_burst_arbiter_if.slave bus
);
  localparam int IW = N_MASTER > 1 ? $clog2(N_MASTER) : 1;
  localparam int CW = $clog2((2 ** MAX_SIZE) / BEAT_BYTES) + 1;
  localparam logic [3:0] LBB = 4'($clog2(BEAT_BYTES));
  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, beats;
  logic [IW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, gnt, arb_idx, ptr_adv;
  logic          arb_vld, hs, multi;
  logic [3:0]    sz;
  DATA_T         sel;

  tl_rr_picker #(.N(N_MASTER), .IW(IW)) u_picker (
    .req_i (bus.inp_valid_i),
    .base_i(ARB_MODE == ARB_RR ? ptr_q : '0),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign gnt              = state_q == IDLE ? arb_idx : gnt_q;
  assign sel              = bus.inp_bits_i[gnt];
  assign bus.oup_bits_o   = sel;
  assign bus.oup_valid_o  = rst_i && (state_q == IDLE ? arb_vld : bus.inp_valid_i[gnt_q]);
  assign hs               = bus.oup_valid_o && bus.oup_ready_i;
  assign bus.inp_ready_o  = hs ? N_MASTER'(1) << gnt : '0;
  assign bus.lock_valid_o = state_q != IDLE;
  assign bus.lock_idx_o   = gnt_q;
  assign sz               = 4'(sel.size);
  assign multi            = is_data_op(tl_a_op_e'(sel.opcode)) && sz > LBB;
  assign beats            = multi ? CW'(1) << (sz - LBB) : CW'(1);
  // Priority only moves past the winner once its last beat has been taken
  assign ptr_adv = ARB_MODE != ARB_RR ? ptr_q : gnt == IW'(N_MASTER - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    if (state_q != BURST) begin
      if (bus.oup_valid_o && !bus.oup_ready_i) state_d = HOLD;
      if (hs) begin
        state_d = multi ? BURST : IDLE;
        cnt_d   = multi ? beats - 1'b1 : '0;
        ptr_d   = multi ? ptr_q : ptr_adv;
      end
    end else if (hs) begin
      state_d = cnt_q == CW'(1) ? IDLE : BURST;
      cnt_d   = cnt_q - 1'b1;
      ptr_d   = cnt_q == CW'(1) ? ptr_adv : ptr_q;
    end
    if (state_d != IDLE) gnt_d = gnt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule

// File: tb/tb_tl_burst_arbiter.sv
// tb_tl_burst_arbiter: scoreboard bench; expected handshakes are queued with the stimulus and
// popped as the round-robin arbiter accepts beats, with a fixed-priority twin on the same inputs.
module tb_tl_burst_arbiter;
  import tl_pkg::*;
  typedef struct {int m; int k; int c;} exp_t;
  logic clk_i, rst_i, rdy;
  logic [3:0] en;
  int n_cmp = 0, n_err = 0, cyc = 0;
  tl_a_chan_t mq [4][$];
  exp_t exp_q[$];
  logic s_ov, s_lv;
  logic [1:0] s_li;
  logic [7:0] s_src, s_fsrc;
  logic [3:0] s_fr;

  tl_burst_arbiter_if #(.N_MASTER(4)) bus ();
  tl_burst_arbiter_if #(.N_MASTER(4)) bus_f ();
  assign bus_f.inp_bits_i  = bus.inp_bits_i;
  assign bus_f.inp_valid_i = bus.inp_valid_i;
  assign bus_f.oup_ready_i = bus.oup_ready_i;

  tl_burst_arbiter #(.N_MASTER(4), .ARB_MODE(ARB_RR)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  tl_burst_arbiter #(.N_MASTER(4), .ARB_MODE(ARB_FIXED)) dut_f (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_f));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_txn(int m, tl_a_op_e op, int size, int nb, int k0);
    for (int k = 0; k < nb; k++) begin
      tl_a_chan_t t;
      t = '0;
      t.opcode = op;
      t.size = 4'(size);
      t.source = 8'(m);
      t.data = 64'(m * 256 + k0 + k);
      mq[m].push_back(t);
    end
  endfunction

  function automatic void exp_hs(int m, int k, int c);
    exp_q.push_back('{m, k, c});
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.inp_valid_i[i] = en[i] && mq[i].size() != 0;
      bus.inp_bits_i[i] = mq[i].size() != 0 ? mq[i][0] : '0;
    end
    bus.oup_ready_i = rdy;
  endtask

  task automatic step();
    logic [3:0] acc;
    exp_t e;
    drive();
    @(negedge clk_i);
    s_ov = bus.oup_valid_o;
    s_lv = bus.lock_valid_o;
    s_li = bus.lock_idx_o;
    s_src = bus.oup_bits_o.source;
    s_fr = bus_f.inp_ready_o;
    s_fsrc = bus_f.oup_bits_o.source;
    acc = bus.inp_ready_o;
    if (s_ov && rdy) begin
      if (exp_q.size() == 0) chk("unexpected_hs", 64'(acc), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("grant", 64'(acc), 64'(4'b1 << e.m));
        chk("source", 64'(s_src), 64'(e.m));
        chk("data", bus.oup_bits_o.data, 64'(e.m * 256 + e.k));
        chk("cycle", 64'(cyc), 64'(e.c));
      end
    end else chk("stall_ready", 64'(acc), 64'd0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i] && mq[i].size() != 0) void'(mq[i].pop_front());
    cyc++;
  endtask

  task automatic done(string tag);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    en = '1;
    rdy = 1'b1;
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_i = 1'b0;
    rdy = 1'b1;
    en = '1;
    push_txn(0, PUT_FULL_DATA, 5, 4, 0);
    push_txn(2, GET, 3, 1, 0);
    drive();
    #3;
    chk("rst_ready", 64'(bus.inp_ready_o), 64'd0);
    chk("rst_valid", 64'(bus.oup_valid_o), 64'd0);
    chk("rst_lock", 64'(bus.lock_valid_o), 64'd0);
    chk("rst_lock_idx", 64'(bus.lock_idx_o), 64'd0);
    reset();

    // 4-beat put from m0 beats a simultaneous Get from m1, which follows on cycle 4
    push_txn(0, PUT_FULL_DATA, 5, 4, 0);
    push_txn(1, GET, 3, 1, 0);
    for (int k = 0; k < 4; k++) exp_hs(0, k, k);
    exp_hs(1, 0, 4);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 5) chk("burst_lock", 64'(s_lv), 64'(c >= 1 && c <= 3));
    end
    done("burst_drain");

    reset();
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 4; m++) begin
        push_txn(m, GET, 3, 1, r);
        exp_hs(m, r, r * 4 + m);
      end
    repeat (9) step();
    done("rr_drain");

    // m2 stalled by ready; m1 shows up mid-stall and must not steal the held grant
    reset();
    push_txn(2, GET, 3, 1, 0);
    push_txn(1, GET, 3, 1, 0);
    exp_hs(2, 0, 3);
    exp_hs(1, 0, 4);
    for (int c = 0; c < 6; c++) begin
      rdy = c >= 3;
      en = c >= 2 ? 4'b1111 : 4'b1101;
      step();
      if (c < 3) begin
        chk("hold_src", 64'(s_src), 64'd2);
        chk("hold_lock", 64'(s_lv), 64'(c > 0));
      end
      if (c == 2) chk("hold_lock_idx", 64'(s_li), 64'd2);
    end
    done("hold_drain");

    reset();
    push_txn(0, PUT_FULL_DATA, 3, 1, 0);
    push_txn(1, GET, 6, 1, 0);
    push_txn(2, PUT_PARTIAL_DATA, 4, 2, 0);
    push_txn(3, ARITHMETIC_DATA, 6, 8, 0);
    exp_hs(0, 0, 0);
    exp_hs(1, 0, 1);
    exp_hs(2, 0, 2);
    exp_hs(2, 1, 3);
    for (int k = 0; k < 8; k++) exp_hs(3, k, 4 + k);
    for (int c = 0; c < 14; c++) begin
      step();
      if (c < 5) chk("size_lock", 64'(s_lv), 64'(c == 3));
    end
    done("size_drain");

    // locked m0 drops valid for a cycle; m1 stays pending behind the bubble
    reset();
    push_txn(0, PUT_FULL_DATA, 4, 2, 0);
    push_txn(1, GET, 3, 1, 0);
    exp_hs(0, 0, 0);
    exp_hs(0, 1, 2);
    exp_hs(1, 0, 3);
    for (int c = 0; c < 5; c++) begin
      en = c == 1 ? 4'b1110 : 4'b1111;
      step();
      if (c == 1) begin
        chk("bubble_valid", 64'(s_ov), 64'd0);
        chk("bubble_lock", 64'(s_lv), 64'd1);
        chk("bubble_lock_idx", 64'(s_li), 64'd0);
      end
    end
    done("bubble_drain");

    reset();
    push_txn(0, PUT_FULL_DATA, 5, 4, 0);
    exp_hs(0, 0, 0);
    exp_hs(0, 1, 1);
    step();
    step();
    done("midrst_drain");
    rst_i = 1'b0;
    #1;
    chk("midrst_lock", 64'(bus.lock_valid_o), 64'd0);
    chk("midrst_lock_idx", 64'(bus.lock_idx_o), 64'd0);
    chk("midrst_ready", 64'(bus.inp_ready_o), 64'd0);
    chk("midrst_valid", 64'(bus.oup_valid_o), 64'd0);
    reset();
    push_txn(3, GET, 3, 1, 0);
    exp_hs(3, 0, 0);
    step();
    chk("midrst_after_lock", 64'(s_lv), 64'd0);
    step();
    done("midrst_after_drain");

    reset();
    for (int r = 0; r < 8; r++) begin
      push_txn(1, GET, 3, 1, r);
      push_txn(3, GET, 3, 1, r);
    end
    for (int c = 0; c < 6; c++) exp_hs(c % 2 == 0 ? 1 : 3, c / 2, c);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("fixed_ready", 64'(s_fr), 64'(4'b0010));
      chk("fixed_src", 64'(s_fsrc), 64'd1);
    end
    done("fixed_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
